// File: rtl/shiftleds_ctrl_arb.sv
// Round-robin ownership arbiter for the shiftleds datapath. Each handover
// resets the datapath. Only the owner's switch word is forwarded.
module shiftleds_ctrl_arb #(
  parameter int N_REQ      = 3,
  parameter int NB_SW      = 4,
  parameter int NB_ID      = 2,
  parameter int HOLD_MAX   = 1024,
  parameter int NB_HOLD    = 11,
  parameter int RST_CYCLES = 4,
  parameter int NB_RST     = 3
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*NB_SW-1:0] i_sw_bus,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [NB_ID-1:0]       o_owner,
  output logic [NB_SW-1:0]       o_sw,
  output logic                   o_sr_rst,
  output logic                   o_busy,
  output logic                   o_timeout
);

  typedef enum logic [1:0] {IDLE, HANDOVER, OWN} state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [NB_ID-1:0]   owner_q;
  logic [NB_SW-1:0]   sw_q;
  logic               sr_rst_q;
  logic               busy_q;
  logic               timeout_q;
  logic [NB_ID-1:0]   ptr_q;
  logic [NB_HOLD-1:0] hold_q;
  logic [NB_RST-1:0]  rst_cnt_q;

  logic               win_vld_d;
  logic [NB_ID-1:0]   win_idx_d;
  logic [NB_ID-1:0]   ptr_inc_d;
  logic [NB_SW-1:0]   own_sw_d;
  logic               owner_req_d;
  logic               waiter_d;
  int                 off;
  int                 best;

  // Winner is the requester with the smallest circular distance from ptr.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    best      = N_REQ;
    off       = 0;
    for (int j = 0; j < N_REQ; j++) begin
      off = j - int'(ptr_q);
      if (off < 0) off = off + N_REQ;
      if (i_req[j] && (off < best)) begin
        best      = off;
        win_idx_d = NB_ID'(j);
        win_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    own_sw_d = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (owner_q == NB_ID'(j)) own_sw_d = i_sw_bus[j*NB_SW +: NB_SW];
    end
  end

  assign ptr_inc_d   = (owner_q == NB_ID'(N_REQ-1)) ? '0 : owner_q + NB_ID'(1);
  assign owner_req_d = |(i_req & gnt_q);
  assign waiter_d    = |(i_req & ~gnt_q);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      sw_q      <= '0;
      sr_rst_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
      rst_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sw_q     <= '0;
          sr_rst_q <= 1'b0;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          if (win_vld_d) begin
            state_q   <= HANDOVER;
            gnt_q     <= N_REQ'(1) << win_idx_d;
            owner_q   <= win_idx_d;
            sr_rst_q  <= 1'b1;
            busy_q    <= 1'b1;
            rst_cnt_q <= '0;
            hold_q    <= '0;
          end
        end
        HANDOVER: begin
          if (!owner_req_d) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            sw_q     <= '0;
            sr_rst_q <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= ptr_inc_d;
          end else if (rst_cnt_q == NB_RST'(RST_CYCLES-1)) begin
            state_q  <= OWN;
            sr_rst_q <= 1'b0;
            sw_q     <= own_sw_d;
          end else begin
            rst_cnt_q <= rst_cnt_q + NB_RST'(1);
          end
        end
        OWN: begin
          // Owner drop takes precedence, so a tie with the timeout is a normal release.
          if (!owner_req_d || (waiter_d && (hold_q == NB_HOLD'(HOLD_MAX-1)))) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sw_q      <= '0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= ptr_inc_d;
            timeout_q <= owner_req_d;
          end else begin
            sw_q   <= own_sw_d;
            hold_q <= waiter_d ? hold_q + NB_HOLD'(1) : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gnt     = gnt_q;
  assign o_owner   = owner_q;
  assign o_sw      = sw_q;
  assign o_sr_rst  = sr_rst_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_shiftleds_ctrl_arb.sv
// Scoreboard bench for shiftleds_ctrl_arb: an ownership-age reference model
// queues the expected outputs of every cycle and a monitor compares them.
module tb_shiftleds_ctrl_arb;

  localparam int N_REQ = 3;
  localparam int NB_SW = 4;
  localparam int NB_ID = 2;
  localparam int HOLD  = 16;
  localparam int RSTC  = 4;

  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [NB_ID-1:0] owner;
    logic [NB_SW-1:0] sw;
    logic             srRst;
    logic             busy;
    logic             timeout;
  } exp_t;

  logic                   clock;
  logic                   i_reset;
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*NB_SW-1:0] i_sw_bus;
  logic [N_REQ-1:0]       o_gnt;
  logic [NB_ID-1:0]       o_owner;
  logic [NB_SW-1:0]       o_sw;
  logic                   o_sr_rst;
  logic                   o_busy;
  logic                   o_timeout;

  int   testsRun  = 0;
  int   failCount = 0;
  exp_t expQ[$];

  shiftleds_ctrl_arb #(
    .N_REQ(N_REQ), .NB_SW(NB_SW), .NB_ID(NB_ID), .HOLD_MAX(HOLD),
    .NB_HOLD(5), .RST_CYCLES(RSTC), .NB_RST(3)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_req(i_req), .i_sw_bus(i_sw_bus),
    .o_gnt(o_gnt), .o_owner(o_owner), .o_sw(o_sw), .o_sr_rst(o_sr_rst),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [N_REQ*NB_SW-1:0] sw,
                               input logic rst, input int n);
    @(negedge clock);
    i_req    = req;
    i_sw_bus = sw;
    i_reset  = rst;
    repeat (n) @(posedge clock);
  endtask

  // Reference model: tracks who owns, how long ownership has lasted and how
  // long others have waited; outputs follow from those ages directly.
  int   mOwner = -1;
  int   mAge   = 0;
  int   mHold  = 0;
  int   mPtr   = 0;
  int   mWin;
  int   mCand;
  exp_t mCur   = '0;

  task automatic modelRelease(input logic isTimeout);
    mPtr          = (mOwner + 1) % N_REQ;
    mOwner        = -1;
    mHold         = 0;
    mCur.gnt      = '0;
    mCur.sw       = '0;
    mCur.srRst    = 1'b0;
    mCur.busy     = 1'b0;
    mCur.timeout  = isTimeout;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      mCur.timeout = 1'b0;
      if (i_reset) begin
        mCur   = '0;
        mOwner = -1;
        mPtr   = 0;
        mHold  = 0;
        mAge   = 0;
      end else if (mOwner < 0) begin
        mWin = -1;
        for (int k = 0; k < N_REQ; k++) begin
          mCand = (mPtr + k) % N_REQ;
          if (mWin < 0 && i_req[mCand]) mWin = mCand;
        end
        mCur.gnt   = '0;
        mCur.sw    = '0;
        mCur.srRst = 1'b0;
        mCur.busy  = 1'b0;
        if (mWin >= 0) begin
          mOwner     = mWin;
          mAge       = 1;
          mHold      = 0;
          mCur.gnt   = N_REQ'(1) << mWin;
          mCur.owner = NB_ID'(mWin);
          mCur.srRst = 1'b1;
          mCur.busy  = 1'b1;
        end
      end else if (!i_req[mOwner]) begin
        modelRelease(1'b0);
      end else if (mAge < RSTC) begin
        mAge++;
      end else if (mAge == RSTC) begin
        mAge++;
        mCur.srRst = 1'b0;
        mCur.sw    = i_sw_bus[mOwner*NB_SW +: NB_SW];
      end else begin
        if ((i_req & ~(N_REQ'(1) << mOwner)) != 0) begin
          if (mHold == HOLD - 1) modelRelease(1'b1);
          else mHold++;
        end else begin
          mHold = 0;
        end
        if (mOwner >= 0) mCur.sw = i_sw_bus[mOwner*NB_SW +: NB_SW];
      end
      expQ.push_back(mCur);
    end
  end

  exp_t actual;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      actual = {o_gnt, o_owner, o_sw, o_sr_rst, o_busy, o_timeout};
      if (expQ.size() == 0) begin
        checkOutput("scoreboard empty", 32'd1, 32'd0);
      end else begin
        checkOutput("cycle outputs", 32'(actual), 32'(expQ.pop_front()));
      end
      checkOutput("grant onehot", 32'($countones(o_gnt) <= 1), 32'd1);
    end
  end

  logic [N_REQ-1:0]       reqR;
  logic [N_REQ*NB_SW-1:0] swR;

  initial begin
    i_reset  = 1'b1;
    i_req    = '0;
    i_sw_bus = '0;
    applyStimulus('0, '0, 1'b1, 3);
    #2;
    checkOutput("reset state", 32'({o_gnt, o_owner, o_sw, o_sr_rst, o_busy, o_timeout}), 32'd0);

    // Single requester grant latency
    applyStimulus(3'b010, 12'h0B0, 1'b0, 1);
    #2;
    checkOutput("t1 gnt", 32'(o_gnt), 32'b010);
    checkOutput("t1 owner", 32'(o_owner), 32'd1);
    checkOutput("t1 sr_rst first", 32'(o_sr_rst), 32'd1);
    checkOutput("t1 sw during handover", 32'(o_sw), 32'd0);
    applyStimulus(3'b010, 12'h0B0, 1'b0, 3);
    #2;
    checkOutput("t1 sr_rst last", 32'(o_sr_rst), 32'd1);
    applyStimulus(3'b010, 12'h0B0, 1'b0, 1);
    #2;
    checkOutput("t1 sr_rst done", 32'(o_sr_rst), 32'd0);
    checkOutput("t1 sw valid", 32'(o_sw), 32'hB);
    checkOutput("t1 busy", 32'(o_busy), 32'd1);
    applyStimulus(3'b010, 12'h0B0, 1'b0, 4);
    applyStimulus('0, '0, 1'b0, 2);

    // Round robin 0,1,2,0 with all three requesting
    applyStimulus('0, '0, 1'b1, 1);
    for (int g = 0; g < 4; g++) begin
      applyStimulus(3'b111, 12'h5A3, 1'b0, 1 + RSTC + 10);
      #2;
      checkOutput("t2 owner order", 32'(o_owner), 32'(g % N_REQ));
      applyStimulus(3'b111 & ~(3'b001 << (g % N_REQ)), 12'h5A3, 1'b0, 1);
      #2;
      checkOutput("t2 idle gap", 32'({o_gnt, o_sw}), 32'd0);
    end
    applyStimulus('0, '0, 1'b0, 2);

    // Forced release after HOLD waiting cycles
    applyStimulus(3'b001, 12'h007, 1'b0, 5);
    applyStimulus(3'b011, 12'h007, 1'b0, HOLD);
    #2;
    checkOutput("t3 timeout pulse", 32'(o_timeout), 32'd1);
    checkOutput("t3 gnt at timeout", 32'(o_gnt), 32'd0);
    applyStimulus(3'b011, 12'h007, 1'b0, 1);
    #2;
    checkOutput("t3 waiter granted", 32'(o_gnt), 32'b010);
    checkOutput("t3 timeout cleared", 32'(o_timeout), 32'd0);
    applyStimulus('0, '0, 1'b0, 2);

    // Sole owner holding for a long time with changing switch words
    for (int i = 0; i < 5000; i++) begin
      applyStimulus(3'b001, 12'($urandom), 1'b0, 1);
    end
    #2;
    checkOutput("t4 still owner", 32'(o_gnt), 32'b001);
    applyStimulus('0, '0, 1'b0, 2);

    // Abort in the second handover cycle, then reset while owning
    applyStimulus(3'b100, 12'h900, 1'b0, 2);
    applyStimulus('0, 12'h900, 1'b0, 1);
    #2;
    checkOutput("t5 abort idle", 32'({o_gnt, o_sr_rst, o_busy}), 32'd0);
    applyStimulus(3'b011, 12'h021, 1'b0, 1);
    #2;
    checkOutput("t5 search from 0", 32'(o_gnt), 32'b001);
    applyStimulus(3'b011, 12'h021, 1'b0, RSTC + 2);
    applyStimulus(3'b011, 12'h021, 1'b1, 1);
    #2;
    checkOutput("t5 reset in own", 32'({o_gnt, o_owner, o_sw, o_sr_rst, o_busy, o_timeout}), 32'd0);
    applyStimulus('0, '0, 1'b0, 2);

    // Owner drop coincides with the last hold cycle
    applyStimulus(3'b001, 12'h0C5, 1'b0, 5);
    applyStimulus(3'b011, 12'h0C5, 1'b0, HOLD - 1);
    applyStimulus(3'b010, 12'h0C5, 1'b0, 1);
    #2;
    checkOutput("t6 no timeout", 32'(o_timeout), 32'd0);
    checkOutput("t6 released", 32'(o_gnt), 32'd0);
    applyStimulus(3'b010, 12'h0C5, 1'b0, 1);
    #2;
    checkOutput("t6 waiter granted", 32'(o_gnt), 32'b010);
    applyStimulus('0, '0, 1'b0, 2);

    // Random traffic with sticky requests and rare resets
    reqR = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) reqR = N_REQ'($urandom_range(7));
      swR = 12'($urandom);
      applyStimulus(reqR, swR, ($urandom_range(299) == 0), 1);
    end

    @(posedge clock);
    #3;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
